led_shifter_gen: RTL and testbench

//   Parametrised successor to the fixed 16-bit LED shifter. Holds a WIDTH-bit LED pattern that

---
 rtl/led_shifter_gen.sv | 117 +++++++++++
 tb/tb_led_shifter_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_shifter_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_shifter_gen
//  Description : WIDTH-bit LED pattern register that advances once per
//                prescaled step in FILL, DRAIN, ROTATE or BOUNCE mode, with
//                load/clear control, display blanking and status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module led_shifter_gen #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [PRESCALE_W-1:0] period_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  input  logic                  clear_i,
  input  logic                  off_i,
  output logic [WIDTH-1:0]      leds_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  step_o,
  output logic                  dir_o
);

  localparam logic [1:0] MODE_FILL   = 2'b00;
  localparam logic [1:0] MODE_DRAIN  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      pattern_q, pattern_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  tick;

  // Prescaler tick; '>=' lets a shortened period fire at once instead of wrapping
  always_comb begin
    tick   = en_i & (cnt_q >= period_i);
    step_o = tick & ~clear_i & ~load_i;
  end

  // Next-state: clear beats load beats step beats hold
  always_comb begin
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    if (clear_i) begin
      pattern_d = '0;
      cnt_d     = '0;
      dir_d     = 1'b0;
    end else if (load_i) begin
      pattern_d = load_val_i;
      cnt_d     = '0;
      dir_d     = 1'b0;
    end else if (en_i) begin
      if (tick) begin
        cnt_d = '0;
        case (mode_i)
          MODE_FILL:   pattern_d = {pattern_q[WIDTH-2:0], 1'b1};
          MODE_DRAIN:  pattern_d = {1'b0, pattern_q[WIDTH-1:1]};
          MODE_ROTATE: pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
          MODE_BOUNCE: begin
            // An empty pattern has nothing to bounce; direction is kept too
            if (pattern_q != '0) begin
              if (!dir_q) begin
                if (pattern_q[WIDTH-1]) begin
                  dir_d     = 1'b1;
                  pattern_d = pattern_q >> 1;
                end else begin
                  pattern_d = pattern_q << 1;
                end
              end else begin
                if (pattern_q[0]) begin
                  dir_d     = 1'b0;
                  pattern_d = pattern_q << 1;
                end else begin
                  pattern_d = pattern_q >> 1;
                end
              end
            end
          end
          default: pattern_d = pattern_q;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pattern_q <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

  // Display and status outputs; blanking affects only the LED pins
  always_comb begin
    leds_o  = off_i ? '0 : pattern_q;
    full_o  = &pattern_q;
    empty_o = ~|pattern_q;
    dir_o   = dir_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_shifter_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_shifter_gen
//  Description : Self-checking bench for led_shifter_gen against an
//                arithmetic reference model of the LED pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_shifter_gen;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, en, load, clear, off;
  logic [1:0]    mode;
  logic [PW-1:0] period;
  logic [W-1:0]  load_val;
  logic [W-1:0]  leds;
  logic          full, empty, step, dir;

  int checks = 0;
  int errors = 0;

  // Reference model state as plain integers
  int m_q, m_cnt, m_dir;

  led_shifter_gen #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .period_i(period),
    .load_i(load), .load_val_i(load_val), .clear_i(clear), .off_i(off),
    .leds_o(leds), .full_o(full), .empty_o(empty), .step_o(step), .dir_o(dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the spec's rules in integer arithmetic
  task automatic model_edge();
    int tick;
    tick = (en && m_cnt >= int'(period)) ? 1 : 0;
    if (rst) begin
      m_q = 0; m_cnt = 0; m_dir = 0;
    end else if (clear) begin
      m_q = 0; m_cnt = 0; m_dir = 0;
    end else if (load) begin
      m_q = int'(load_val); m_cnt = 0; m_dir = 0;
    end else if (en) begin
      if (tick == 1) begin
        m_cnt = 0;
        case (mode)
          2'b00: m_q = (m_q * 2 + 1) % 65536;
          2'b01: m_q = m_q / 2;
          2'b10: m_q = (m_q * 2) % 65536 + m_q / 32768;
          default: begin
            if (m_q != 0) begin
              if (m_dir == 0) begin
                if (m_q >= 32768) begin m_dir = 1; m_q = m_q / 2; end
                else m_q = m_q * 2;
              end else begin
                if (m_q % 2 == 1) begin m_dir = 0; m_q = (m_q * 2) % 65536; end
                else m_q = m_q / 2;
              end
            end
          end
        endcase
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Check all outputs mid-cycle, then advance one edge on both DUT and model
  task automatic cycle();
    int exp_step;
    #3;
    exp_step = (en && m_cnt >= int'(period) && !clear && !load) ? 1 : 0;
    chk("step_o", step, exp_step);
    chk("leds_o", leds, off ? 0 : m_q);
    chk("full_o", full, (m_q == 65535) ? 1 : 0);
    chk("empty_o", empty, (m_q == 0) ? 1 : 0);
    chk("dir_o", dir, m_dir);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; clear = 1'b0; off = 1'b0;
    mode = 2'b00; period = '0; load_val = '0;
    m_q = 0; m_cnt = 0; m_dir = 0;
    #12;
    // Reset state
    chk("rst_leds", leds, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    cycle();
    rst = 1'b0;

    // T2: FILL, period 2, step every third cycle up to all ones and holding
    mode = 2'b00; period = 8'd2; en = 1'b1;
    repeat (16 * 3 + 6) cycle();
    chk("t2_fullpat", leds, 16'hFFFF);
    chk("t2_full", full, 1);

    // T3: BOUNCE from 0x0001 at period 0
    mode = 2'b11; period = 8'd0;
    do_load(16'h0001);
    repeat (15) cycle();
    chk("t3_top", leds, 16'h8000);
    cycle();
    chk("t3_rev", leds, 16'h4000);
    chk("t3_dir1", dir, 1);
    repeat (14) cycle();
    chk("t3_bottom", leds, 16'h0001);
    cycle();
    chk("t3_back", leds, 16'h0002);
    chk("t3_dir0", dir, 0);

    // T4: ROTATE, load beats a concurrent tick, then one step
    mode = 2'b10;
    do_load(16'h8001);
    chk("t4_loaded", leds, 16'h8001);
    cycle();
    chk("t4_rot", leds, 16'h0003);

    // T5: shorten period mid-count, then freeze with en low
    period = 8'd200;
    do_load(16'h0001);
    repeat (50) cycle();
    chk("t5_nostep", leds, 16'h0001);
    period = 8'd10;
    cycle();
    chk("t5_early", leds, 16'h0002);
    repeat (4) cycle();
    en = 1'b0;
    repeat (5) cycle();
    chk("t5_frozen", leds, 16'h0002);
    en = 1'b1;
    repeat (25) cycle();

    // T6: DRAIN with display blanked; state still advances
    mode = 2'b01; period = 8'd0;
    do_load(16'hFFFF);
    off = 1'b1;
    repeat (4) cycle();
    chk("t6_blank", leds, 0);
    chk("t6_notempty", empty, 0);
    off = 1'b0;
    #1;
    chk("t6_release", leds, 16'h0FFF);

    // T1: asynchronous reset between edges while bouncing downward
    mode = 2'b11;
    do_load(16'h8000);
    cycle();
    chk("t1_pre_dir", dir, 1);
    #2;
    rst = 1'b1;
    m_q = 0; m_cnt = 0; m_dir = 0;
    #1;
    chk("t1_leds", leds, 0);
    chk("t1_empty", empty, 1);
    chk("t1_dir", dir, 0);
    cycle();
    rst = 1'b0;

    // Randomised operation against the model
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      period   = 8'($urandom_range(0, 4));
      load     = ($urandom_range(0, 19) == 0);
      clear    = ($urandom_range(0, 29) == 0);
      off      = ($urandom_range(0, 5) == 0);
      load_val = 16'($urandom);
      cycle();
    end
    load = 1'b0; clear = 1'b0; off = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
